sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM initiator that reads the two words of the system-ID responder (address 0 = system ID, address 1 = build timestamp) and compares them against expected values. It sits between the Nios/Qsys interconnect and board-level status logic, so firmware and LEDs can confirm that the loaded FPGA image matches the expected build before the oscilloscope datapath is trusted. A check runs once automatically after reset and again on each `start` pulse.

## Interface
- EXPECTED_ID, 0, expected 32-bit word at address 0
- EXPECTED_TIMESTAMP, 1584655414, expected 32-bit word at address 1
- TIMEOUT_CYCLES, 255, maximum wait-stalled cycles per read; 0 disables the timeout
- AUTO_START, 1, 1 = launch one check on the first cycle after reset deasserts

- clock  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read strobe
- avm_waitrequest  in  1  responder stall; read completes on a cycle with avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  read data, valid on the completing cycle (zero read latency)
- busy  out  1  check in progress
- done  out  1  level; high from check completion until the next accepted start
- pass  out  1  valid when done=1; 1 = both words matched and no timeout
- error_code  out  2  00 none, 01 ID mismatch, 10 timestamp mismatch, 11 timeout
- id_value  out  32  captured address-0 word
- timestamp_value  out  32  captured address-1 word

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE/DONE + accepted start (or the AUTO_START trigger) -> RD_ID: clear done, pass, error_code; set busy.
- RD_ID: avm_read=1, avm_address=0; hold both stable while avm_waitrequest=1. On completion, capture avm_readdata into id_value -> RD_TS.
- RD_TS: same with avm_address=1; capture into timestamp_value -> CHECK.
- CHECK: one cycle; compare captured values -> DONE with busy=0, done=1, and pass/error_code set.
- Error priority: timeout > ID mismatch > timestamp mismatch. Both words are always read unless a timeout occurs.
- Timeout: a per-read stall counter, cleared when each read starts, increments on every avm_waitrequest=1 cycle. On reaching TIMEOUT_CYCLES, drop avm_read and go directly to DONE with error_code=11 and pass=0. id_value/timestamp_value for reads that did not complete are left at 0.
- A start while busy is dropped; it is not queued.
- A start in DONE is accepted on that cycle.

## Timing
- Reset values: all outputs 0, except avm_address=0 and state=IDLE. avm_read drops asynchronously on reset assertion, including mid-read. A stalled transfer is abandoned and no captures occur.
- With AUTO_START=1, the first cycle after reset release counts as start cycle N.
- Start accepted in cycle N -> avm_read=1 in N+1.
- With zero wait states: ID read in N+1, timestamp read in N+2, CHECK in N+3, done=1 in N+4.
- Each wait-stalled cycle adds one cycle.
- avm_read is never asserted in two consecutive transfers without an address change. There is no idle cycle between the ID and timestamp reads.
- Stall counter is 8 bits wide minimum, sized by $clog2(TIMEOUT_CYCLES+1).

## Structure
- Shared package `sysid_checker_pkg`: state enum, error-code constants (ERR_NONE, ERR_ID, ERR_TS, ERR_TIMEOUT), address constants ADDR_ID=0 and ADDR_TS=1.
- One natural sub-module: `sysid_read_timer`, the stall counter with clear/enable/expired outputs.
- The FSM, capture registers and compare logic stay in the top level.

## Test plan
- Responder returns 0 at address 0 and 1584655414 at address 1, no waits, AUTO_START=1 -> done=1, pass=1, error_code=00 exactly 4 cycles after reset release.
- Responder returns 5 at address 0 -> done with pass=0, error_code=01, id_value=5. The timestamp is still read.
- Responder returns 1584655415 at address 1, with 3 wait cycles on each read -> error_code=10. done occurs at N+10. Address and read stay stable during every stall.
- avm_waitrequest held high, TIMEOUT_CYCLES=255 -> avm_read drops after 255 stall cycles, error_code=11, pass=0.
- Start pulsed while busy and again in DONE, then reset asserted mid-RD_TS -> busy start is ignored and the DONE start relaunches. On reset, avm_read=0 immediately and all outputs return to 0.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared definitions for the system-ID checker: state encoding, error codes,
// responder word addresses and the stall-counter width rule.
package sysid_checker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_ID = 3'd1;
  localparam state_t ST_RD_TS = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Stall counter is never narrower than 8 bits.
  function automatic int stall_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read stall counter: counts wait-stalled cycles and flags the cycle on
// which the stall budget is used up. TIMEOUT_CYCLES = 0 disables expiry.
module sysid_read_timer
  import sysid_checker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int             W     = stall_cnt_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // reset in the sensitivity list, so every flop updates from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry fires on the stall cycle that brings the total to TIMEOUT_CYCLES.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LIMIT - 1'b1);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM initiator that reads the system-ID and build-timestamp words and
// reports whether the loaded image matches the expected build.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1584655414,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error_code,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_auto_pending;
  logic        r_pass;
  logic [1:0]  r_error_code;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic w_in_read;
  logic w_rd_done;
  logic w_launch;
  logic w_timeout;

  assign w_in_read = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign w_rd_done = w_in_read && !avm_waitrequest;
  assign w_launch  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                     (start || r_auto_pending);

  sysid_read_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (!w_in_read || w_rd_done),
    .i_enable  (w_in_read && avm_waitrequest),
    .o_expired (w_timeout)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_launch) w_state_next = ST_RD_ID;
      ST_RD_ID: begin
        if (w_timeout)      w_state_next = ST_DONE;
        else if (w_rd_done) w_state_next = ST_RD_TS;
      end
      ST_RD_TS: begin
        if (w_timeout)      w_state_next = ST_DONE;
        else if (w_rd_done) w_state_next = ST_CHECK;
      end
      ST_CHECK: w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_auto_pending <= AUTO_START;
      r_pass         <= 1'b0;
      r_error_code   <= ERR_NONE;
      r_id_value     <= '0;
      r_ts_value     <= '0;
    end else begin
      r_state <= w_state_next;

      // A new check starts from a clean slate, including the captured words.
      if (w_launch) begin
        r_auto_pending <= 1'b0;
        r_pass         <= 1'b0;
        r_error_code   <= ERR_NONE;
        r_id_value     <= '0;
        r_ts_value     <= '0;
      end

      if (w_timeout) begin
        r_error_code <= ERR_TIMEOUT;
      end else if ((r_state == ST_RD_ID) && w_rd_done) begin
        r_id_value <= avm_readdata;
      end else if ((r_state == ST_RD_TS) && w_rd_done) begin
        r_ts_value <= avm_readdata;
      end

      if (r_state == ST_CHECK) begin
        if (r_id_value != EXPECTED_ID) begin
          r_error_code <= ERR_ID;
        end else if (r_ts_value != EXPECTED_TIMESTAMP) begin
          r_error_code <= ERR_TS;
        end else begin
          r_error_code <= ERR_NONE;
          r_pass       <= 1'b1;
        end
      end
    end
  end

  // Bus strobes decode straight from the state flop, so reset drops them at once.
  assign avm_read        = w_in_read;
  assign avm_address     = (r_state == ST_RD_TS) ? ADDR_TS : ADDR_ID;
  assign busy            = w_in_read || (r_state == ST_CHECK);
  assign done            = (r_state == ST_DONE);
  assign pass            = r_pass;
  assign error_code      = r_error_code;
  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: a behavioural responder, a result model
// that predicts each check outcome and its completion cycle, and a done monitor.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1584655414;
  localparam int          TMO    = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata    = 32'd0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  error_code;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;

  always #5 clock = ~clock;

  sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_code      (error_code),
    .id_value        (id_value),
    .timestamp_value (timestamp_value)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Expected outcome of one check and the negedge-sampled cycle of done rising.
  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          at;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] id, input logic [31:0] ts,
                                 input int waits, input bit hold, input int c);
    exp_t e;
    if (hold) begin
      e.pass = 1'b0; e.err = 2'd3; e.id = 32'd0; e.ts = 32'd0;
      e.at   = c + TMO + 1;
    end else begin
      e.id = id; e.ts = ts;
      e.at = c + 4 + 2 * waits;
      if (id != EXP_ID)      begin e.pass = 1'b0; e.err = 2'd1; end
      else if (ts != EXP_TS) begin e.pass = 1'b0; e.err = 2'd2; end
      else                   begin e.pass = 1'b1; e.err = 2'd0; end
    end
    return e;
  endfunction

  // Responder: fixed wait states per transfer (or stall forever), zero-latency data.
  logic [31:0] rsp_id    = EXP_ID;
  logic [31:0] rsp_ts    = EXP_TS;
  int          rsp_waits = 0;
  bit          rsp_hold  = 1'b0;

  int   w_left    = 0;
  int   stall_run = 0;
  logic prev_rd   = 1'b0;
  logic prev_wr   = 1'b0;
  logic prev_addr = 1'b0;

  always @(negedge clock) begin
    if (!reset && prev_rd && prev_wr) begin
      if (avm_read) check("addr_held_in_stall", avm_address, prev_addr);
      else          check("stall_cycles_at_timeout", stall_run, TMO);
    end
    if (!reset && prev_rd && !prev_wr && avm_read)
      check("addr_changes_between_reads", avm_address, !prev_addr);

    if (!avm_read) begin
      stall_run       = 0;
      avm_waitrequest = 1'b0;
      avm_readdata    = $urandom;
    end else begin
      if (!(prev_rd && prev_wr)) begin
        w_left    = rsp_waits;
        stall_run = 0;
      end
      if (rsp_hold || w_left > 0) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = $urandom;
        w_left--;
        stall_run++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = avm_address ? rsp_ts : rsp_id;
      end
    end
    prev_rd   = avm_read;
    prev_wr   = avm_waitrequest;
    prev_addr = avm_address;
  end

  // Monitor: every rising edge of done retires one scoreboard entry.
  exp_t mon_e;
  logic prev_done = 1'b0;

  always @(negedge clock) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done rose at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pass",            pass,            mon_e.pass);
        check("error_code",      error_code,      mon_e.err);
        check("id_value",        id_value,        mon_e.id);
        check("timestamp_value", timestamp_value, mon_e.ts);
        check("done_cycle",      cyc,             mon_e.at);
        check("busy_at_done",    busy,            1'b0);
      end
    end
    prev_done = done;
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < TMO + 50) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles, %0d check(s) outstanding", n, sb.size());
      sb.delete();
    end
  endtask

  // Called at a negedge with the DUT idle or done.
  task automatic launch(input logic [31:0] id, input logic [31:0] ts,
                        input int waits, input bit hold, input bit poke);
    rsp_id    = id;
    rsp_ts    = ts;
    rsp_waits = waits;
    rsp_hold  = hold;
    sb.push_back(model(id, ts, waits, hold, cyc));
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (poke) begin
      @(negedge clock);
      check("busy_when_poked", busy, 1'b1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avm_read"},        avm_read,        1'b0);
    check({tag, "_avm_address"},     avm_address,     1'b0);
    check({tag, "_busy"},            busy,            1'b0);
    check({tag, "_done"},            done,            1'b0);
    check({tag, "_pass"},            pass,            1'b0);
    check({tag, "_error_code"},      error_code,      2'd0);
    check({tag, "_id_value"},        id_value,        32'd0);
    check({tag, "_timestamp_value"}, timestamp_value, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rid;
    logic [31:0] rts;
    int          rw;
    int          n;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");

    // Auto-start: release counts as start cycle N, done expected at N+4.
    rsp_id = EXP_ID; rsp_ts = EXP_TS; rsp_waits = 0; rsp_hold = 1'b0;
    sb.push_back(model(EXP_ID, EXP_TS, 0, 1'b0, cyc));
    reset = 1'b0;
    wait_drain();

    launch(32'd5,  EXP_TS,        0, 1'b0, 1'b0);
    launch(EXP_ID, EXP_TS + 32'd1, 3, 1'b0, 1'b0);
    launch(EXP_ID, EXP_TS,        0, 1'b0, 1'b1);
    launch(EXP_ID, EXP_TS,        0, 1'b1, 1'b0);
    launch(EXP_ID, EXP_TS,        2, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      rid = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      case ($urandom_range(0, 2))
        0:       rts = EXP_TS;
        1:       rts = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
        default: rts = $urandom;
      endcase
      rw = $urandom_range(0, 4);
      launch(rid, rts, rw, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a stalled timestamp read.
    rsp_id = 32'd5; rsp_ts = EXP_TS; rsp_waits = 4; rsp_hold = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(avm_read && avm_address) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reached_rd_ts", avm_read && avm_address, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midread_reset");
    repeat (3) @(negedge clock);
    check_all_zero("held_reset");

    rsp_id = EXP_ID; rsp_ts = EXP_TS; rsp_waits = 1;
    sb.push_back(model(EXP_ID, EXP_TS, 1, 1'b0, cyc));
    reset = 1'b0;
    wait_drain();

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
